// File: rtl/pulse_pkg.sv
// Shared types and helpers for the pulse shrinker.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HIGH    = 2'd1,
    LOCKOUT = 2'd2
  } ps_state_e;

  // Bits needed to hold a count from 0 up to and including max_val.
  function automatic int width_clog2(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Single-bit synchroniser chain. Every flop resets to 1, so a line that is
// high when reset is released does not present a fresh rising edge.
// STAGES=0 makes the block a wire.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q = d;
    end else begin : g_chain
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic stage_reg;
        if (gi == 0) begin : g_first
          // First stage captures the raw input.
          always_ff @(posedge clk) begin
            if (rst) stage_reg <= 1'b1;
            else     stage_reg <= d;
          end
        end else begin : g_next
          // Later stages shift the previous stage along.
          always_ff @(posedge clk) begin
            if (rst) stage_reg <= 1'b1;
            else     stage_reg <= g_stage[gi-1].stage_reg;
          end
        end
      end
      assign q = g_stage[STAGES-1].stage_reg;
    end
  endgenerate

endmodule

// File: rtl/pulse_shrinker.sv
// Measures the high width of a stretched input pulse and compresses an
// accepted pulse back into a one-cycle strobe with its width alongside.
// Pulses shorter than MIN_WIDTH flag err_short; pulses longer than
// MAX_WIDTH flag err_long and are then ignored until the input drops.
module pulse_shrinker
  import pulse_pkg::*;
#(
  parameter int MIN_WIDTH   = 4,
  parameter int MAX_WIDTH   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = width_clog2(MAX_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pin,
  output logic             pout,
  output logic [CNT_W-1:0] width,
  output logic             width_valid,
  output logic             err_short,
  output logic             err_long
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WIDTH);

  logic             pin_s;
  logic             pin_d_reg;

  ps_state_e        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] width_reg, width_next;
  logic             pout_reg, pout_next;
  logic             err_short_reg, err_short_next;
  logic             err_long_reg, err_long_next;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (pin),
    .q  (pin_s)
  );

  // Edge-detect delay; resets high so a level already present is not an edge.
  always_ff @(posedge clk) begin
    if (rst) pin_d_reg <= 1'b1;
    else     pin_d_reg <= pin_s;
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      width_reg     <= '0;
      pout_reg      <= 1'b0;
      err_short_reg <= 1'b0;
      err_long_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      width_reg     <= width_next;
      pout_reg      <= pout_next;
      err_short_reg <= err_short_next;
      err_long_reg  <= err_long_next;
    end
  end

  // Next-state and flag decode; flags default low so each is one cycle wide.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    width_next     = width_reg;
    pout_next      = 1'b0;
    err_short_next = 1'b0;
    err_long_next  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (pin_s && !pin_d_reg) begin
          cnt_next   = CNT_W'(1);
          state_next = HIGH;
        end
      end
      HIGH: begin
        if (pin_s) begin
          if (cnt_reg == MAX_C) begin
            // One sample beyond the limit: give up on this pulse.
            err_long_next = 1'b1;
            state_next    = LOCKOUT;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end else begin
          width_next = cnt_reg;
          state_next = IDLE;
          if (cnt_reg >= MIN_C) pout_next      = 1'b1;
          else                  err_short_next = 1'b1;
        end
      end
      LOCKOUT: begin
        // Wait silently for the over-long pulse to end.
        if (!pin_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign pout        = pout_reg;
  assign width_valid = pout_reg;
  assign width       = width_reg;
  assign err_short   = err_short_reg;
  assign err_long    = err_long_reg;

endmodule

// File: tb/tb_pulse_shrinker.sv
// Randomised and directed bench for pulse_shrinker with a queue scoreboard.
module tb_pulse_shrinker;

  localparam int MIN_W = 4;
  localparam int MAX_W = 16;
  localparam int SYNC  = 2;
  localparam int CW    = $clog2(MAX_W + 1);

  localparam int K_ACCEPT = 0;
  localparam int K_SHORT  = 1;
  localparam int K_LONG   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pin = 1'b0;
  logic          pout;
  logic [CW-1:0] width;
  logic          width_valid;
  logic          err_short;
  logic          err_long;

  pulse_shrinker #(
    .MIN_WIDTH  (MIN_W),
    .MAX_WIDTH  (MAX_W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pin        (pin),
    .pout       (pout),
    .width      (width),
    .width_valid(width_valid),
    .err_short  (err_short),
    .err_long   (err_long)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int w;
    int at;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  model_width = 0;
  int  exp_width = 0;

  // Monitor state
  ev_t mev;
  int  nflags;
  int  kind_act;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pulse of L high samples followed by gap low samples. The expected
  // outcome comes straight from the width rules: too short, accepted, or
  // too long (flagged at the first sample past MAX_W, width untouched).
  task automatic pulse(input int L, input int gap);
    int  s;
    ev_t ev;
    s = cyc + 1;
    if (L < MIN_W) begin
      ev = '{K_SHORT, L, s + L + SYNC};
      model_width = L;
    end else if (L <= MAX_W) begin
      ev = '{K_ACCEPT, L, s + L + SYNC};
      model_width = L;
    end else begin
      ev = '{K_LONG, model_width, s + MAX_W + SYNC};
    end
    exp_q.push_back(ev);
    $display("STIM pulse len=%0d gap=%0d expect kind=%0d width=%0d at=%0d",
             L, gap, ev.kind, ev.w, ev.at);
    pin = 1'b1;
    repeat (L) tick();
    pin = 1'b0;
    repeat (gap) tick();
  endtask

  // Monitor: compares every flagged cycle against the scoreboard and checks
  // that width holds its value in all other cycles.
  always @(negedge clk) begin
    if (rst) begin
      exp_width = 0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        mev = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event kind=%0d expected at cycle %0d, now cycle %0d",
                 mev.kind, mev.at, cyc);
      end
      nflags = int'(pout) + int'(err_short) + int'(err_long);
      checks++;
      if (nflags > 1 || width_valid !== pout) begin
        errors++;
        $display("FAIL flag_exclusive pout=%0b wv=%0b short=%0b long=%0b at cycle %0d",
                 pout, width_valid, err_short, err_long, cyc);
      end
      if (nflags != 0) begin
        kind_act = pout ? K_ACCEPT : (err_short ? K_SHORT : K_LONG);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event kind=%0d width=%0d at cycle %0d, required none",
                   kind_act, width, cyc);
        end else begin
          mev = exp_q.pop_front();
          if (kind_act != mev.kind || cyc != mev.at || width !== CW'(mev.w)) begin
            errors++;
            $display("FAIL event got kind=%0d width=%0d cycle=%0d, required kind=%0d width=%0d cycle=%0d",
                     kind_act, width, cyc, mev.kind, mev.w, mev.at);
          end else begin
            $display("EVENT kind=%0d width=%0d cycle=%0d ok", kind_act, width, cyc);
          end
          exp_width = mev.w;
        end
      end else if (width !== CW'(exp_width)) begin
        errors++;
        $display("FAIL width_hold got %0d required %0d at cycle %0d", width, exp_width, cyc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    pin = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (pout !== 1'b0 || width_valid !== 1'b0 || err_short !== 1'b0 ||
        err_long !== 1'b0 || width !== '0) begin
      errors++;
      $display("FAIL reset_state pout=%0b wv=%0b short=%0b long=%0b width=%0d, required all 0",
               pout, width_valid, err_short, err_long, width);
    end
    tick();
    repeat (4) tick();

    // Directed cases
    pulse(6, 4);
    pulse(2, 4);
    pulse(3, 4);
    pulse(4, 4);
    pulse(16, 4);
    pulse(20, 4);
    pulse(17, 4);
    pulse(1, 4);
    pulse(5, 1);
    pulse(7, 4);

    // Reset in the middle of a pulse; pin stays high across deassertion.
    $display("STIM reset mid-pulse");
    pin = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    model_width = 0;
    repeat (4) tick();
    pin = 1'b0;
    repeat (4) tick();
    pulse(5, 4);

    // Randomised pulses covering short, accepted, boundary and long widths.
    for (int i = 0; i < 40; i++) begin
      pulse(int'($urandom_range(1, MAX_W + 6)), int'($urandom_range(1, 4)));
    end

    repeat (30) tick();
    while (exp_q.size() > 0) begin
      mev = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL leftover_event kind=%0d width=%0d expected at cycle %0d never seen",
               mev.kind, mev.w, mev.at);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
